// File: rtl/adbg_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : adbg_wb_arbiter
// Description : Two-requester Wishbone arbiter. Requester 0 is the debug bus
//               module and requester 1 is a second master. Ties are resolved
//               round-robin. Once a requester owns the bus it keeps it until
//               it drops cyc, so bursts are never preempted.
//               Optional stall watchdog: define ADBG_WB_ARB_WATCHDOG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module adbg_wb_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                                wb_clk_i,
  input  logic                                wb_rst_i,
  // Requester side
  input  logic [1:0]                          m_cyc_i,
  input  logic [1:0]                          m_stb_i,
  input  logic [1:0]                          m_we_i,
  input  logic [1:0][ADDR_WIDTH-1:0]          m_adr_i,
  input  logic [1:0][DATA_WIDTH/8-1:0]        m_sel_i,
  input  logic [1:0][DATA_WIDTH-1:0]          m_dat_i,
  input  logic [1:0][2:0]                     m_cti_i,
  input  logic [1:0][1:0]                     m_bte_i,
  output logic [DATA_WIDTH-1:0]               m_dat_o,
  output logic [1:0]                          m_ack_o,
  output logic [1:0]                          m_err_o,
  output logic [1:0]                          grant_o,
  // Shared bus side
  output logic                                wb_cyc_o,
  output logic                                wb_stb_o,
  output logic                                wb_we_o,
  output logic [ADDR_WIDTH-1:0]               wb_adr_o,
  output logic [DATA_WIDTH/8-1:0]             wb_sel_o,
  output logic [DATA_WIDTH-1:0]               wb_dat_o,
  output logic [2:0]                          wb_cti_o,
  output logic [1:0]                          wb_bte_o,
  input  logic [DATA_WIDTH-1:0]               wb_dat_i,
  input  logic                                wb_ack_i,
  input  logic                                wb_err_i
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN0 = 2'd1;
  localparam logic [1:0] ST_OWN1 = 2'd2;

  logic [1:0] state_q, state_d;
  logic       last_owner_q, last_owner_d;

  logic       w_own;      // some requester currently owns the bus
  logic       w_idx;      // index of the current owner (valid when w_own)
  logic       w_stall;    // owner is strobing and the slave has not answered
  logic       w_timeout;  // watchdog fires this cycle

  assign w_own   = (state_q == ST_OWN0) || (state_q == ST_OWN1);
  assign w_idx   = (state_q == ST_OWN1);
  assign w_stall = w_own && m_stb_i[w_idx] && !wb_ack_i && !wb_err_i;

`ifdef ADBG_WB_ARB_WATCHDOG_EN
  localparam logic [15:0] TIMEOUT_M1 = 16'(TIMEOUT - 1);

  logic [15:0] wd_cnt_q, wd_cnt_d;

  // The counter holds the number of earlier consecutive stall cycles, so the
  // TIMEOUT-th stall cycle is the one where it reads TIMEOUT-1.
  assign w_timeout = w_stall && (wd_cnt_q == TIMEOUT_M1);

  // Watchdog next-state: count stall cycles, clear on any progress or expiry.
  always_comb begin
    wd_cnt_d = 16'd0;
    if (w_stall && !w_timeout) begin
      wd_cnt_d = wd_cnt_q + 16'd1;
    end
  end

  // Watchdog counter register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wd_cnt_q <= 16'd0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // Ownership FSM next-state: round-robin on ties, hold until cyc drops.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    case (state_q)
      ST_IDLE: begin
        if (m_cyc_i[0] && m_cyc_i[1]) begin
          state_d = last_owner_q ? ST_OWN0 : ST_OWN1;
        end else if (m_cyc_i[0]) begin
          state_d = ST_OWN0;
        end else if (m_cyc_i[1]) begin
          state_d = ST_OWN1;
        end
      end
      ST_OWN0, ST_OWN1: begin
        if (!m_cyc_i[w_idx] || w_timeout) begin
          state_d      = ST_IDLE;
          last_owner_d = w_idx;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state registers; reset makes requester 0 win the first tie.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q      <= ST_IDLE;
      last_owner_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
    end
  end

  // Output steering: bus fields follow the owner, responses go only to it.
  always_comb begin
    grant_o  = 2'b00;
    wb_cyc_o = 1'b0;
    wb_stb_o = 1'b0;
    m_ack_o  = 2'b00;
    m_err_o  = 2'b00;
    wb_we_o  = m_we_i[w_idx];
    wb_adr_o = m_adr_i[w_idx];
    wb_sel_o = m_sel_i[w_idx];
    wb_dat_o = m_dat_i[w_idx];
    wb_cti_o = m_cti_i[w_idx];
    wb_bte_o = m_bte_i[w_idx];
    if (w_own) begin
      grant_o[w_idx] = 1'b1;
      wb_cyc_o       = m_cyc_i[w_idx];
      wb_stb_o       = m_stb_i[w_idx];
      m_ack_o[w_idx] = wb_ack_i;
      m_err_o[w_idx] = wb_err_i;
      if (w_timeout) begin
        wb_cyc_o       = 1'b0;
        wb_stb_o       = 1'b0;
        m_err_o[w_idx] = 1'b1;
      end
    end
  end

  // Read data is broadcast unconditionally; requesters qualify it with ack.
  assign m_dat_o = wb_dat_i;

endmodule
`default_nettype wire

// File: tb/tb_adbg_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_adbg_wb_arbiter
// Description : Directed self-checking bench for adbg_wb_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adbg_wb_arbiter;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [1:0]            m_cyc, m_stb, m_we;
  logic [1:0][31:0]      m_adr, m_dat;
  logic [1:0][3:0]       m_sel;
  logic [1:0][2:0]       m_cti;
  logic [1:0][1:0]       m_bte;
  logic [31:0]           m_dat_o;
  logic [1:0]            m_ack_o, m_err_o, grant_o;
  logic                  wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0]           wb_adr_o, wb_dat_o;
  logic [3:0]            wb_sel_o;
  logic [2:0]            wb_cti_o;
  logic [1:0]            wb_bte_o;
  logic [31:0]           wb_dat_i;
  logic                  wb_ack_i, wb_err_i;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  adbg_wb_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(8)) dut (
    .wb_clk_i(clk),      .wb_rst_i(rst),
    .m_cyc_i(m_cyc),     .m_stb_i(m_stb),     .m_we_i(m_we),
    .m_adr_i(m_adr),     .m_sel_i(m_sel),     .m_dat_i(m_dat),
    .m_cti_i(m_cti),     .m_bte_i(m_bte),
    .m_dat_o(m_dat_o),   .m_ack_o(m_ack_o),   .m_err_o(m_err_o),
    .grant_o(grant_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
    .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance one edge and settle just after it.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    m_cyc = 2'b00; m_stb = 2'b00; m_we = 2'b00;
    m_adr[0] = 32'h0000_1000; m_adr[1] = 32'h0000_2000;
    m_dat[0] = 32'hAAAA_0000; m_dat[1] = 32'hBBBB_1111;
    m_sel[0] = 4'hF;          m_sel[1] = 4'h3;
    m_cti = '0; m_bte = '0;
    wb_dat_i = 32'h1234_5678; wb_ack_i = 1'b0; wb_err_i = 1'b0;
    tick(2);
    rst = 1'b0;

    // Reset state; a stray ack in IDLE must be dropped.
    wb_ack_i = 1'b1; wb_err_i = 1'b1;
    #1;
    chk("rst_grant", grant_o, 2'b00);
    chk("rst_cyc",   wb_cyc_o, 1'b0);
    chk("rst_stb",   wb_stb_o, 1'b0);
    chk("idle_ack",  m_ack_o, 2'b00);
    chk("idle_err",  m_err_o, 2'b00);
    chk("dat_bcast", m_dat_o, 32'h1234_5678);
    wb_ack_i = 1'b0; wb_err_i = 1'b0;

    // Single request from requester 0, one-cycle grant latency.
    m_cyc = 2'b01; m_stb = 2'b01; m_we = 2'b01;
    #1;
    chk("lat_grant0", grant_o, 2'b00);
    tick();
    chk("g0_grant", grant_o, 2'b01);
    chk("g0_adr",   wb_adr_o, 32'h0000_1000);
    chk("g0_dat",   wb_dat_o, 32'hAAAA_0000);
    chk("g0_ctl",   {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o}, {3'b111, 4'hF});
    wb_ack_i = 1'b1;
    #1;
    chk("g0_ack", m_ack_o, 2'b01);
    wb_ack_i = 1'b0; wb_err_i = 1'b1;
    #1;
    chk("g0_err", m_err_o, 2'b01);
    wb_err_i = 1'b0;
    m_cyc = 2'b00; m_stb = 2'b00; m_we = 2'b00;
    tick();
    chk("g0_release", grant_o, 2'b00);

    // Fresh reset, simultaneous requests: requester 0 wins first.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_cyc = 2'b11; m_stb = 2'b11;
    tick();
    chk("tie_grant0", grant_o, 2'b01);
    chk("tie_adr0",   wb_adr_o, 32'h0000_1000);
    m_cyc = 2'b10; m_stb = 2'b10;
    tick();
    chk("gap_idle", grant_o, 2'b00);
    chk("gap_cyc",  wb_cyc_o, 1'b0);
    tick();
    chk("tie_grant1", grant_o, 2'b10);
    chk("g1_adr",     wb_adr_o, 32'h0000_2000);
    chk("g1_sel",     wb_sel_o, 4'h3);

    // Owner 1 burst while requester 0 waits: no preemption.
    m_cyc = 2'b11; m_stb = 2'b11; m_cti[1] = 3'b010; m_bte[1] = 2'b00;
    wb_ack_i = 1'b1;
    for (int b = 0; b < 4; b++) begin
      if (b == 3) m_cti[1] = 3'b111;
      #1;
      chk("burst_grant", grant_o, 2'b10);
      chk("burst_ack",   m_ack_o, 2'b10);
      chk("burst_cti",   wb_cti_o, (b == 3) ? 3'b111 : 3'b010);
      tick();
    end
    wb_ack_i = 1'b0;
    chk("burst_hold", grant_o, 2'b10);
    m_cyc = 2'b01; m_stb = 2'b01; m_cti[1] = 3'b000;
    tick();
    chk("burst_idle", grant_o, 2'b00);
    tick();
    chk("rr_grant0", grant_o, 2'b01);

    // Owner 0 releases, both request at IDLE: last owner was 0, so 1 wins.
    m_cyc = 2'b10;
    tick();
    chk("rr_idle", grant_o, 2'b00);
    m_cyc = 2'b11;
    tick();
    chk("rr_grant1", grant_o, 2'b10);

    // Reset mid-cycle during OWN0 with strobe active.
    m_cyc = 2'b00; m_stb = 2'b00;
    tick();
    m_cyc = 2'b01; m_stb = 2'b01;
    tick();
    chk("pre_rst_stb", {grant_o, wb_stb_o}, {2'b01, 1'b1});
    rst = 1'b1;
    tick();
    chk("mid_rst_cyc",   wb_cyc_o, 1'b0);
    chk("mid_rst_grant", grant_o, 2'b00);
    rst = 1'b0;

    // Stalled owner 0: first OWN0 cycle is stall cycle 1.
    tick();
    chk("stall_grant", grant_o, 2'b01);
`ifdef ADBG_WB_ARB_WATCHDOG_EN
    tick(6);
    chk("wd_pre_err", m_err_o, 2'b00);
    chk("wd_pre_cyc", wb_cyc_o, 1'b1);
    tick();
    chk("wd_err", m_err_o, 2'b01);
    chk("wd_cyc", {wb_cyc_o, wb_stb_o}, 2'b00);
    tick();
    chk("wd_idle", grant_o, 2'b00);
`else
    tick(20);
    chk("nowd_cyc",   wb_cyc_o, 1'b1);
    chk("nowd_err",   m_err_o, 2'b00);
    chk("nowd_grant", grant_o, 2'b01);
`endif

    m_cyc = 2'b00; m_stb = 2'b00;
    tick(2);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/adbg_wb_arbiter.md
ADBG_WB_ARBITER -- requirements
Module: adbg_wb_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, Wishbone address width.
REQ-002 Parameter DATA_WIDTH, default 32, Wishbone data width; sel width is DATA_WIDTH/8.
REQ-003 Parameter TIMEOUT, default 255, stall-watchdog limit in wb_clk_i cycles (range 2..65535).
REQ-004 wb_clk_i  input  1  the block's one clock; all logic on its rising edge.
REQ-005 wb_rst_i  input  1  reset, synchronous and active-high.
REQ-006 m_cyc_i  input  [1:0]  per-requester cycle request; index 0 = debug bus module, index 1 = second master.
REQ-007 m_stb_i  input  [1:0]  per-requester strobe.
REQ-008 m_we_i  input  [1:0]  per-requester write enable.
REQ-009 m_adr_i  input  [1:0][ADDR_WIDTH-1:0]  per-requester address.
REQ-010 m_sel_i  input  [1:0][DATA_WIDTH/8-1:0]  per-requester byte selects.
REQ-011 m_dat_i  input  [1:0][DATA_WIDTH-1:0]  per-requester write data.
REQ-012 m_cti_i  input  [1:0][2:0]  per-requester cycle type.
REQ-013 m_bte_i  input  [1:0][1:0]  per-requester burst type.
REQ-014 m_dat_o  output  DATA_WIDTH  read data broadcast to both requesters.
REQ-015 m_ack_o  output  [1:0]  per-requester acknowledge.
REQ-016 m_err_o  output  [1:0]  per-requester error.
REQ-017 grant_o  output  [1:0]  one-hot current owner; 2'b00 when idle.
REQ-018 wb_cyc_o, wb_stb_o, wb_we_o  output  1 each  shared-bus master controls.
REQ-019 wb_adr_o / wb_sel_o / wb_dat_o / wb_cti_o / wb_bte_o  output  ADDR_WIDTH / DATA_WIDTH/8 / DATA_WIDTH / 3 / 2  shared-bus fields.
REQ-020 wb_dat_i, wb_ack_i, wb_err_i  input  DATA_WIDTH, 1, 1  shared-bus slave response.

Function
REQ-021 FSM states IDLE, OWN0, OWN1, plus registered last_owner bit.
REQ-022 IDLE: grant_o=00, wb_cyc_o=0, wb_stb_o=0, all m_ack_o/m_err_o=0.
REQ-023 IDLE with exactly one m_cyc_i high -> OWNn of that requester on next edge (1-cycle grant latency).
REQ-024 IDLE with both m_cyc_i high -> grant requester != last_owner (round-robin).
REQ-025 OWNn: wb_cyc_o=m_cyc_i[n], wb_stb_o=m_stb_i[n]; we/adr/sel/dat/cti/bte combinationally muxed from requester n.
REQ-026 OWNn: m_ack_o[n]=wb_ack_i, m_err_o[n]=wb_err_i; other requester's ack/err held 0.
REQ-027 Ownership locked while m_cyc_i[n]=1, incl. across bursts and idle stb cycles; no preemption.
REQ-028 m_cyc_i[n] falls in OWNn -> IDLE on next edge, last_owner<=n; at least one IDLE cycle between owners.
REQ-029 m_dat_o=wb_dat_i at all times.
REQ-030 wb_ack_i/wb_err_i arriving in IDLE are dropped.

Reset
REQ-031 wb_rst_i high at an edge -> IDLE, last_owner=1 (requester 0 wins first tie), watchdog=0; takes priority over all transitions, incl. mid-cycle.
REQ-032 Reset values: grant_o=00, wb_cyc_o=0, wb_stb_o=0, m_ack_o=00, m_err_o=00; mux outputs don't-care when cyc=0.

Configuration
REQ-033 Macro ADBG_WB_ARB_WATCHDOG_EN defined: 16-bit counter increments each OWNn cycle with wb_stb_o=1 and no wb_ack_i/wb_err_i, clears otherwise; at TIMEOUT, m_err_o[n]=1 for one cycle, wb_cyc_o/wb_stb_o forced 0 that cycle, FSM -> IDLE, last_owner<=n.
REQ-034 Macro undefined: no counter logic; TIMEOUT ignored; a stalled cycle holds the bus indefinitely.

Verification
REQ-035 Reset, then m_cyc_i=01, m_stb_i=01, adr0=0x1000 -> next cycle grant_o=01, wb_adr_o=0x1000; wb_ack_i -> m_ack_o=01.
REQ-036 From reset, m_cyc_i=11 same cycle -> grant_o=01; req0 drops cyc -> one IDLE cycle, then grant_o=10.
REQ-037 Owner 1 runs 4-beat burst (cti=010, last 111) while req0 requests -> grant_o stays 10 until m_cyc_i[1]=0; m_ack_o[0] stays 0.
REQ-038 wb_rst_i pulsed during OWN0 with wb_stb_o=1 -> next edge wb_cyc_o=0, grant_o=00.
REQ-039 Watchdog enabled, TIMEOUT=8, owner 0 strobes with no ack -> m_err_o=01 on 8th stall cycle, wb_cyc_o=0, then IDLE; disabled build: cyc stays high after 20 cycles.
